// File: rtl/noise_synth_pkg.sv
// Shared constants, frame type and duty mapping for the noise synth voice blocks.
package noise_synth_pkg;

    localparam logic [3:0] ADDR_VOLUME    = 4'd0;
    localparam logic [3:0] ADDR_DECAY     = 4'd1;
    localparam logic [3:0] ADDR_CTRL      = 4'd2;
    localparam int         CTRL_TRIG_BIT  = 0;
    localparam int         CTRL_MUTE_BIT  = 1;
    localparam logic [7:0] DUTY_MID       = 8'd128;
    localparam int         SPI_FRAME_BITS = 16;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } spi_frame_t;

    // Half the level swings the duty either side of mid-scale: 1..255.
    function automatic logic [7:0] calc_duty(input logic [7:0] level,
                                             input logic       mute,
                                             input logic       noise);
        logic [7:0] h;
        logic [7:0] duty;
        h = {1'b0, level[7:1]};
        if (mute || level == 8'd0)
            duty = DUTY_MID;
        else if (noise)
            duty = DUTY_MID + h;
        else
            duty = DUTY_MID - h;
        return duty;
    endfunction

endpackage

// File: rtl/noise_env_dac_spi_frame_rx.sv
// SPI mode-0 16-bit frame receiver: synchronisers, shifter, one-cycle frame strobe.
module spi_frame_rx
    import noise_synth_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clock,
    input  logic       spi_data,
    input  logic       spi_cs,
    output logic       frame_valid,
    output spi_frame_t frame
);

    localparam logic [4:0] FRAME_CNT = 5'(SPI_FRAME_BITS);

    logic [2:0]                sck_sync_reg;
    logic [2:0]                cs_sync_reg;
    logic [1:0]                mosi_sync_reg;
    logic [SPI_FRAME_BITS-1:0] shift_reg;
    logic [4:0]                bit_cnt_reg;
    logic                      frame_valid_reg;
    spi_frame_t                frame_reg;
    logic                      sck_rise;
    logic                      cs_high;
    logic                      cs_rise;

    assign sck_rise = sck_sync_reg[1] & ~sck_sync_reg[2];
    assign cs_high  = cs_sync_reg[1];
    assign cs_rise  = cs_sync_reg[1] & ~cs_sync_reg[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_reg    <= 3'b000;
            cs_sync_reg     <= 3'b111;
            mosi_sync_reg   <= 2'b00;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            frame_valid_reg <= 1'b0;
            frame_reg       <= '0;
        end else begin
            sck_sync_reg  <= {sck_sync_reg[1:0], spi_clock};
            cs_sync_reg   <= {cs_sync_reg[1:0], spi_cs};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_data};

            if (cs_high) begin
                bit_cnt_reg <= '0;
            end else if (sck_rise) begin
                shift_reg <= {shift_reg[SPI_FRAME_BITS-2:0], mosi_sync_reg[1]};
                // Saturate so over-long frames can never alias back to 16.
                if (bit_cnt_reg != 5'd31)
                    bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end

            frame_valid_reg <= cs_rise && (bit_cnt_reg == FRAME_CNT);
            if (cs_rise) begin
                frame_reg.addr <= shift_reg[15:12];
                frame_reg.data <= shift_reg[7:0];
            end
        end
    end

    assign frame_valid = frame_valid_reg;
    assign frame       = frame_reg;

endmodule

// File: rtl/noise_env_dac.sv
// Noise volume/decay envelope feeding an 8-bit PWM output; define
// NOISE_ENV_SIGMA_DELTA_EN to use a first-order sigma-delta output instead.
module noise_env_dac
    import noise_synth_pkg::*;
#(
    parameter int DECAY_PRESCALE = 256,
    parameter int NOISE_SYNC     = 0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic noise_in,
    input  logic spi_clock,
    input  logic spi_data,
    input  logic spi_cs,
    output logic audio_out,
    output logic env_active
);

    localparam int            PW         = $clog2(DECAY_PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DECAY_PRESCALE - 1);

    logic          frame_valid;
    spi_frame_t    frame;
    logic          noise_s;
    logic          tick;
    logic [7:0]    volume_reg;
    logic [7:0]    decay_reg;
    logic          mute_reg;
    logic [7:0]    level_reg;
    logic [7:0]    duty_latch_reg;
    logic [7:0]    pwm_cnt_reg;
    logic [PW-1:0] presc_reg;
    logic [7:0]    decay_cnt_reg;
    logic          env_active_reg;
    logic          audio_out_reg;

    spi_frame_rx u_spi_rx (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .spi_clock   (spi_clock),
        .spi_data    (spi_data),
        .spi_cs      (spi_cs),
        .frame_valid (frame_valid),
        .frame       (frame)
    );

    generate
        if (NOISE_SYNC != 0) begin : gen_noise_sync
            logic [1:0] noise_sync_reg;
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n)
                    noise_sync_reg <= 2'b00;
                else
                    noise_sync_reg <= {noise_sync_reg[0], noise_in};
            end
            assign noise_s = noise_sync_reg[1];
        end else begin : gen_noise_direct
            assign noise_s = noise_in;
        end
    endgenerate

    assign tick = (presc_reg == PRESC_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            volume_reg     <= DUTY_MID;
            decay_reg      <= 8'd0;
            mute_reg       <= 1'b0;
            level_reg      <= 8'd0;
            duty_latch_reg <= DUTY_MID;
            pwm_cnt_reg    <= 8'd0;
            presc_reg      <= '0;
            decay_cnt_reg  <= 8'd0;
            env_active_reg <= 1'b0;
        end else begin
            pwm_cnt_reg    <= pwm_cnt_reg + 8'd1;
            presc_reg      <= tick ? '0 : presc_reg + 1'b1;
            env_active_reg <= (level_reg != 8'd0);

            // A committed frame takes priority; any coincident decay tick is lost.
            if (frame_valid) begin
                case (frame.addr)
                    ADDR_VOLUME: volume_reg <= frame.data;
                    ADDR_DECAY:  decay_reg  <= frame.data;
                    ADDR_CTRL: begin
                        mute_reg <= frame.data[CTRL_MUTE_BIT];
                        if (frame.data[CTRL_TRIG_BIT]) begin
                            level_reg     <= volume_reg;
                            decay_cnt_reg <= 8'd0;
                            presc_reg     <= '0;
                        end
                    end
                    default: ;
                endcase
            end else if (tick && decay_reg != 8'd0) begin
                if (decay_cnt_reg + 8'd1 == decay_reg) begin
                    decay_cnt_reg <= 8'd0;
                    if (level_reg != 8'd0)
                        level_reg <= level_reg - 8'd1;
                end else begin
                    decay_cnt_reg <= decay_cnt_reg + 8'd1;
                end
            end

            // Only update the duty at the period boundary so a period is never split.
            if (pwm_cnt_reg == 8'hFF)
                duty_latch_reg <= calc_duty(level_reg, mute_reg, noise_s);
        end
    end

`ifdef NOISE_ENV_SIGMA_DELTA_EN
    logic [8:0] acc_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_reg       <= 9'd0;
            audio_out_reg <= 1'b0;
        end else begin
            acc_reg       <= {1'b0, acc_reg[7:0]} + {1'b0, duty_latch_reg};
            audio_out_reg <= acc_reg[8];
        end
    end
`else
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            audio_out_reg <= 1'b0;
        else
            audio_out_reg <= (pwm_cnt_reg < duty_latch_reg);
    end
`endif

    assign audio_out  = audio_out_reg;
    assign env_active = env_active_reg;

endmodule
